// File: rtl/muldiv_pkg.sv
// Shared types, constants and arithmetic helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDiv  = 2'b10,
    StDone = 2'b11
  } state_e;

  localparam logic [31:0] DivZeroQ = 32'hFFFF_FFFF;
  localparam logic [31:0] IntMin   = 32'h8000_0000;

  // Magnitude of a value that is optionally interpreted as two's complement.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Shift-add multiply and restoring divide on
// magnitudes, one bit per clock, with a final sign-fixup cycle and a one-cycle write-back.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] opnd_q, opnd_d;    // multiplicand (MUL) or divisor (DIV) magnitude
  logic [63:0] acc_q, acc_d;      // MUL: {hi, multiplier}; DIV: {remainder, quotient}
  logic [5:0]  cnt_q, cnt_d;
  logic        sa_q, sa_d;        // effective sign of operand A
  logic        sb_q, sb_d;        // effective sign of operand B
  logic        special_q, special_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;

  op_e         op_in;
  logic        signed_a, signed_b;
  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [63:0] prod;

  // Next-state, datapath iteration and result fixup.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    special_d = special_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    op_in     = op_e'(op);
    signed_a  = op_in inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    signed_b  = op_in inside {OpMul, OpMulh, OpDiv, OpRem};
    sum       = '0;
    shifted   = '0;
    diff      = '0;
    prod      = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d      = op_in;
          rd_d      = rd_addr;
          cnt_d     = '0;
          special_d = 1'b0;
          sa_d      = signed_a & rs1_val[31];
          sb_d      = signed_b & rs2_val[31];
          if (!op[2]) begin
            opnd_d  = mag32(rs1_val, signed_a);
            acc_d   = {32'd0, mag32(rs2_val, signed_b)};
            state_d = StMul;
          end else begin
            opnd_d  = mag32(rs2_val, signed_b);
            acc_d   = {32'd0, mag32(rs1_val, signed_a)};
            state_d = StDiv;
            // Special cases park their final result in acc low half and finish next edge
            if (rs2_val == 32'd0) begin
              special_d = 1'b1;
              acc_d     = {32'd0, op[1] ? rs1_val : DivZeroQ};
            end else if (signed_a && rs1_val == IntMin && rs2_val == 32'hFFFF_FFFF) begin
              special_d = 1'b1;
              acc_d     = {32'd0, op[1] ? 32'd0 : IntMin};
            end
          end
        end
      end

      StMul: begin
        if (cnt_q == 6'd32) begin
          prod      = cond_neg64(acc_q, sa_q ^ sb_q);
          wb_data_d = (op_q == OpMul) ? prod[31:0] : prod[63:32];
          wb_addr_d = rd_q;
          state_d   = StDone;
        end else begin
          sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
          acc_d = {sum, acc_q[31:1]};
          cnt_d = cnt_q + 6'd1;
        end
      end

      StDiv: begin
        if (special_q) begin
          wb_data_d = acc_q[31:0];
          wb_addr_d = rd_q;
          state_d   = StDone;
        end else if (cnt_q == 6'd32) begin
          wb_data_d = op_q[1] ? cond_neg32(acc_q[63:32], sa_q)
                              : cond_neg32(acc_q[31:0], sa_q ^ sb_q);
          wb_addr_d = rd_q;
          state_d   = StDone;
        end else begin
          shifted = {acc_q[63:32], acc_q[31]};
          diff    = shifted - {1'b0, opnd_q};
          // diff[32] set means the trial subtraction borrowed: restore
          if (!diff[32]) begin
            acc_d = {diff[31:0], acc_q[30:0], 1'b1};
          end else begin
            acc_d = {shifted[31:0], acc_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset clears everything, even mid-operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      rd_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      special_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      special_q <= special_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Outputs: the write strobe is suppressed for x0.
  always_comb begin
    busy    = (state_q != StIdle);
    wb_we   = (state_q == StDone) && (rd_q != 5'd0);
    wb_addr = wb_addr_q;
    wb_data = wb_data_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, reset abort, and random ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_addr (rd_addr),
    .busy    (busy),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics from ordinary 64-bit and 32-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    int         x, y;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    x  = a;
    y  = b;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return x / y;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return x % y;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!o[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Launch one op at edge 0 and watch until busy drops; inject_at>0 pulses a stray start.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int inject_at);
    int          exp_end, end_edge, we_edge, pulses;
    logic [31:0] got_data;
    logic [4:0]  got_addr;
    exp_end  = is_special(o, a, b) ? 2 : 34;
    end_edge = 0;
    we_edge  = 0;
    pulses   = 0;
    got_data = '0;
    got_addr = '0;
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs1_val = a;
    rs2_val = b;
    rd_addr = rd;
    @(posedge clk);
    #1;
    start   = 1'b0;
    op      = 3'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_addr = 5'($urandom);
    check_eq("busy_after_edge0", 32'(busy), 32'd1);
    for (int k = 1; k <= 40 && end_edge == 0; k++) begin
      if (k == inject_at) begin
        start   = 1'b1;
        op      = 3'd0;
        rs1_val = 32'd1000;
        rs2_val = 32'd1000;
        rd_addr = 5'd31;
      end
      @(posedge clk);
      #1;
      if (k == inject_at) start = 1'b0;
      if (wb_we) begin
        pulses++;
        we_edge  = k;
        got_data = wb_data;
        got_addr = wb_addr;
      end
      if (!busy) end_edge = k;
    end
    check_eq("busy_drop_edge", 32'(end_edge), 32'(exp_end));
    check_eq("wb_we_pulses", 32'(pulses), (rd != 0) ? 32'd1 : 32'd0);
    if (rd != 0) begin
      check_eq("wb_we_edge", 32'(we_edge), 32'(exp_end - 1));
      check_eq("wb_data_pulse", got_data, exp);
      check_eq("wb_addr_pulse", 32'(got_addr), 32'(rd));
    end
    check_eq("wb_data_hold", wb_data, exp);
    check_eq("wb_addr_hold", 32'(wb_addr), 32'(rd));
    check_eq("wb_we_idle", 32'(wb_we), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  o;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = '0;
    rs1_val = '0;
    rs2_val = '0;
    rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wb_we", 32'(wb_we), 32'd0);
    check_eq("rst_wb_addr", 32'(wb_addr), 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cases with hand-derived results
    run_op(3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 0);
    run_op(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 0);
    run_op(3'd0, 32'd123, 32'd456, 5'd13, 32'd56088, 10);
    run_op(3'd0, 32'd11, 32'd13, 5'd0, 32'd143, 0);
    run_op(3'd5, 32'd1000, 32'd3, 5'd14, 32'd333, 0);

    // Reset asserted asynchronously in the middle of a DIV
    @(negedge clk);
    start   = 1'b1;
    op      = 3'd4;
    rs1_val = 32'd1000;
    rs2_val = 32'd3;
    rd_addr = 5'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_wb_we", 32'(wb_we), 32'd0);
    check_eq("abort_wb_data", wb_data, 32'd0);
    check_eq("abort_wb_addr", 32'(wb_addr), 32'd0);
    @(posedge clk);
    #1;
    check_eq("abort_held_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd3, 5'd15, 32'd9, 0);

    // Random ops, operands drawn partly from corner values
    for (int i = 0; i < 48; i++) begin
      o = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = {16'd0, a[15:0]};
        3: b = {28'd0, b[3:0]};
        default: ;
      endcase
      run_op(o, a, b, 5'($urandom), ref_result(o, a, b), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
